divider_control: RTL and testbench

Sequencing and output stage directly downstream of the 16-bit pulse counter. Latches a divide target and burst length, drives the counter's `count_enable`, `count_reset` and `count_target`, and consumes its `count_completed`. Each completion produces a fixed-width output pulse on `div_out`, then re-arms the counter. Runs in the system clock domain; the counter's completion flag is asynchronous to it.

---
 rtl/divider_control.sv | 149 ++++++++++++++
 tb/tb_divider_control.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_control.sv
// Sequencer and output stage for the downstream pulse counter: arms/enables the
// counter, turns each completion into a fixed-width div_out pulse, and tracks burst length.
module divider_control #(
  parameter int unsigned PULSE_WIDTH  = 4,
  parameter int unsigned TARGET_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [TARGET_WIDTH-1:0] target_in,
  input  logic [TARGET_WIDTH-1:0] burst_len,
  input  logic                    count_completed,
  output logic                    count_enable,
  output logic                    count_reset,
  output logic [TARGET_WIDTH-1:0] count_target,
  output logic                    div_out,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [TARGET_WIDTH-1:0] pulses_done
);

  localparam int unsigned PCNT_WIDTH = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_COUNT  = 3'd2;
  localparam logic [2:0] S_PULSE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]              state;
  logic [2:0]              state_next;
  logic                    cc_meta;
  logic                    cc_s;
  logic                    cc_d;
  logic                    zero_seen;
  logic [PCNT_WIDTH-1:0]   pulse_cnt;
  logic [TARGET_WIDTH-1:0] burst_q;
  logic                    accept_c;
  logic                    reject_c;
  logic                    cc_rise_c;
  logic                    pulse_last_c;

  assign cc_rise_c    = cc_s & ~cc_d;
  assign pulse_last_c = (pulse_cnt == '0);

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; stop overrides everything outside IDLE
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    reject_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          if (target_in != '0) begin
            accept_c   = 1'b1;
            state_next = S_ARM;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (!cc_s && zero_seen) begin
          state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (cc_rise_c) begin
          state_next = S_PULSE;
        end
      end
      S_PULSE: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (pulse_last_c) begin
          if ((burst_q != '0) && (pulses_done == burst_q)) begin
            state_next = S_FINISH;
          end else begin
            state_next = S_ARM;
          end
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Synchronizer, datapath and registered outputs (outputs follow the next state)
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cc_meta      <= 1'b0;
      cc_s         <= 1'b0;
      cc_d         <= 1'b0;
      zero_seen    <= 1'b0;
      pulse_cnt    <= '0;
      burst_q      <= '0;
      count_target <= '0;
      pulses_done  <= '0;
      count_enable <= 1'b0;
      count_reset  <= 1'b1;
      div_out      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cc_meta   <= count_completed;
      cc_s      <= cc_meta;
      cc_d      <= cc_s;
      // Tracks the first of two consecutive cleared cycles while arming
      zero_seen <= (state == S_ARM) && !cc_s;

      if (accept_c) begin
        count_target <= target_in;
        burst_q      <= burst_len;
        pulses_done  <= '0;
      end

      if ((state != S_PULSE) && (state_next == S_PULSE)) begin
        pulses_done <= pulses_done + TARGET_WIDTH'(1);
        pulse_cnt   <= PCNT_WIDTH'(PULSE_WIDTH - 1);
      end else if ((state == S_PULSE) && !pulse_last_c) begin
        pulse_cnt <= pulse_cnt - PCNT_WIDTH'(1);
      end

      count_enable <= (state_next == S_COUNT);
      count_reset  <= (state_next != S_COUNT);
      div_out      <= (state_next == S_PULSE);
      busy         <= (state_next != S_IDLE);
      done         <= (state_next == S_FINISH);
      cfg_err      <= reject_c;
    end
  end

endmodule

// File: tb/tb_divider_control.sv
// Directed plus randomized bench for divider_control, with a behavioural counter
// feeding count_completed and expectations derived from burst/latency arithmetic.
module tb_divider_control;

  localparam int unsigned PW    = 4;
  localparam int unsigned TW    = 16;
  localparam int unsigned PW2   = 1;
  localparam int unsigned TW2   = 8;
  localparam int          NWRAP = 300;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [TW-1:0] target_in = '0;
  logic [TW-1:0] burst_len = '0;
  logic          count_completed;
  logic          count_enable, count_reset, div_out, busy, done, cfg_err;
  logic [TW-1:0] count_target, pulses_done;

  logic          use_auto = 1'b0;
  logic          cc_man = 1'b0;
  logic          cc_auto = 1'b0;
  int unsigned   auto_cnt = 0;
  assign count_completed = use_auto ? cc_auto : cc_man;

  logic           start2 = 1'b0;
  logic           stop2 = 1'b0;
  logic [TW2-1:0] target2 = '0;
  logic [TW2-1:0] burst2 = '0;
  logic           cc2 = 1'b0;
  int unsigned    cnt2 = 0;
  logic           count_enable2, count_reset2, div_out2, busy2, done2, cfg_err2;
  logic [TW2-1:0] count_target2, pulses_done2;

  int vectors = 0;
  int errors  = 0;

  divider_control #(.PULSE_WIDTH(PW), .TARGET_WIDTH(TW)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .stop(stop),
    .target_in(target_in), .burst_len(burst_len), .count_completed(count_completed),
    .count_enable(count_enable), .count_reset(count_reset), .count_target(count_target),
    .div_out(div_out), .busy(busy), .done(done), .cfg_err(cfg_err), .pulses_done(pulses_done)
  );

  // Narrow instance so the pulse-count wrap is reachable in a short run
  divider_control #(.PULSE_WIDTH(PW2), .TARGET_WIDTH(TW2)) dut2 (
    .clk_in(clk_in), .reset(reset), .start(start2), .stop(stop2),
    .target_in(target2), .burst_len(burst2), .count_completed(cc2),
    .count_enable(count_enable2), .count_reset(count_reset2), .count_target(count_target2),
    .div_out(div_out2), .busy(busy2), .done(done2), .cfg_err(cfg_err2), .pulses_done(pulses_done2)
  );

  // Counter models: flag completion after count_target enabled cycles, clear on count_reset
  always @(posedge clk_in) begin
    if (count_reset === 1'b1) begin
      auto_cnt <= 0;
      cc_auto  <= 1'b0;
    end else if (count_enable === 1'b1) begin
      auto_cnt <= auto_cnt + 1;
      if (auto_cnt + 1 == 32'(count_target)) cc_auto <= 1'b1;
    end
  end

  always @(posedge clk_in) begin
    if (count_reset2 === 1'b1) begin
      cnt2 <= 0;
      cc2  <= 1'b0;
    end else if (count_enable2 === 1'b1) begin
      cnt2 <= cnt2 + 1;
      if (cnt2 + 1 == 32'(count_target2)) cc2 <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_count_reset"}, 32'(count_reset), 1);
    check({pfx, "_count_enable"}, 32'(count_enable), 0);
    check({pfx, "_count_target"}, 32'(count_target), 0);
    check({pfx, "_div_out"}, 32'(div_out), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_done"}, 32'(done), 0);
    check({pfx, "_cfg_err"}, 32'(cfg_err), 0);
    check({pfx, "_pulses_done"}, 32'(pulses_done), 0);
  endtask

  // Advance until n rising edges of div_out have been seen
  task automatic wait_rises(input int n, input int budget);
    int   seen;
    logic prev;
    seen = 0;
    prev = div_out;
    for (int c = 0; c < budget && seen < n; c++) begin
      tick();
      if (div_out && !prev) seen++;
      prev = div_out;
    end
    check("rises_reached", 32'(seen), 32'(n));
  endtask

  // One complete burst: pulse count, width, latency, done/busy sequencing
  task automatic run_burst(input int tgt, input int bl);
    int   pulses, hi, cc_at, budget;
    logic pd, pc;
    bit   fin;
    target_in = TW'(tgt);
    burst_len = TW'(bl);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", 32'(busy), 1);
    check("accept_count_reset", 32'(count_reset), 1);
    check("accept_target", 32'(count_target), 32'(tgt));
    pulses = 0;
    hi     = 0;
    cc_at  = 0;
    pd     = div_out;
    pc     = count_completed;
    fin    = 1'b0;
    budget = bl * (tgt + int'(PW) + 20) + 20;
    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      tick();
      if (count_completed && !pc) cc_at = cyc;
      if (div_out && !pd) begin
        hi = 1;
        check("latency", 32'(cyc - cc_at), 3);
        check("pulses_done_inc", 32'(pulses_done), 32'(pulses + 1));
      end else if (div_out) begin
        hi++;
      end else if (pd) begin
        pulses++;
        check("pulse_width", 32'(hi), 32'(PW));
        if (pulses == bl) begin
          check("done_strobe", 32'(done), 1);
          check("final_count", 32'(pulses_done), 32'(bl));
          check("busy_during_done", 32'(busy), 1);
          tick();
          check("done_clear", 32'(done), 0);
          check("busy_fall", 32'(busy), 0);
          fin = 1'b1;
        end
      end
      if (!fin && done && pulses != bl) check("early_done", 32'(done), 0);
      pd = div_out;
      pc = count_completed;
    end
    if (!fin) check("burst_timeout", 32'(pulses), 32'(bl));
  endtask

  initial begin
    int   last_tgt, tgt, bl, rises, hi;
    logic prev;
    bit   ok;

    // Reset values
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_values("rst");

    // Rejected start with zero target
    target_in = '0;
    burst_len = TW'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_err_strobe", 32'(cfg_err), 1);
    check("cfg_err_busy", 32'(busy), 0);
    check("cfg_err_target", 32'(count_target), 0);
    tick();
    check("cfg_err_clear", 32'(cfg_err), 0);

    // Directed burst then randomized bursts
    use_auto = 1'b1;
    run_burst(5, 3);
    last_tgt = 5;
    for (int k = 0; k < 3; k++) begin
      tgt = int'($urandom_range(12, 1));
      bl  = int'($urandom_range(4, 1));
      run_burst(tgt, bl);
      last_tgt = tgt;
      tick();
    end

    // start and stop together in IDLE: nothing happens
    target_in = TW'(7);
    burst_len = TW'(2);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", 32'(busy), 0);
    check("startstop_target", 32'(count_target), 32'(last_tgt));
    check("startstop_cfg_err", 32'(cfg_err), 0);

    // Continuous run: start during COUNT ignored, stop mid-pulse
    target_in = TW'(5);
    burst_len = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      ok = count_enable;
    end
    check("reach_count", 32'(ok), 1);
    target_in = TW'(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_target", 32'(count_target), 5);
    check("busy_start_busy", 32'(busy), 1);
    wait_rises(3, 200);
    tick();
    check("pre_stop_div", 32'(div_out), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 0);
    check("stop_div", 32'(div_out), 0);
    check("stop_done", 32'(done), 0);
    check("stop_pulses_held", 32'(pulses_done), 3);
    check("stop_count_reset", 32'(count_reset), 1);
    tick();
    check("stop_done_after", 32'(done), 0);
    check("stop_pulses_after", 32'(pulses_done), 3);

    // Rejected start leaves latched target intact
    target_in = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_err2_strobe", 32'(cfg_err), 1);
    check("cfg_err2_busy", 32'(busy), 0);
    check("cfg_err2_target", 32'(count_target), 5);

    // Reset mid-pulse after two high cycles
    target_in = TW'(3);
    burst_len = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rises(1, 60);
    tick();
    check("mid_pulse_div", 32'(div_out), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midrst");
    tick();
    check("midrst_idle", 32'(busy), 0);

    // Completion flag stuck high while arming
    use_auto = 1'b0;
    cc_man = 1'b1;
    target_in = TW'(5);
    burst_len = TW'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("arm_hold_reset", 32'(count_reset), 1);
      check("arm_hold_enable", 32'(count_enable), 0);
      check("arm_hold_busy", 32'(busy), 1);
    end
    cc_man = 1'b0;
    repeat (3) tick();
    check("arm_release_early", 32'(count_enable), 0);
    tick();
    check("arm_release_enable", 32'(count_enable), 1);
    check("arm_release_reset", 32'(count_reset), 0);
    cc_man = 1'b1;
    repeat (2) tick();
    check("manual_lat_low", 32'(div_out), 0);
    tick();
    check("manual_lat_high", 32'(div_out), 1);
    repeat (3) tick();
    check("manual_last_high", 32'(div_out), 1);
    tick();
    check("manual_fall", 32'(div_out), 0);
    check("manual_done", 32'(done), 1);
    cc_man = 1'b0;
    tick();
    check("manual_busy_fall", 32'(busy), 0);
    use_auto = 1'b1;

    // Continuous-mode wrap of the pulse count on the narrow instance
    target2 = TW2'(1);
    burst2  = '0;
    start2  = 1'b1;
    tick();
    start2  = 1'b0;
    rises = 0;
    hi    = 0;
    prev  = div_out2;
    for (int c = 0; c < NWRAP * 20 && rises < NWRAP; c++) begin
      tick();
      if (div_out2 && !prev) begin
        rises++;
        hi = 1;
        if (rises == (1 << TW2)) check("wrap_zero", 32'(pulses_done2), 0);
      end else if (div_out2) begin
        hi++;
      end else if (prev) begin
        check("wrap_width", 32'(hi), 32'(PW2));
      end
      prev = div_out2;
    end
    check("wrap_rises", 32'(rises), 32'(NWRAP));
    check("wrap_value", 32'(pulses_done2), 32'(NWRAP % (1 << TW2)));
    check("wrap_busy", 32'(busy2), 1);
    stop2 = 1'b1;
    tick();
    stop2 = 1'b0;
    check("wrap_stop_busy", 32'(busy2), 0);
    check("wrap_stop_div", 32'(div_out2), 0);
    check("wrap_stop_done", 32'(done2), 0);
    check("wrap_stop_held", 32'(pulses_done2), 32'(NWRAP % (1 << TW2)));
    check("wrap_cfg_err", 32'(cfg_err2), 0);
    tick();
    check("wrap_done_after", 32'(done2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
